// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - write-back commit queue driving the register-file write port with ack handshake
// Optional feature macro: WB_RETIRE_CNT_EN enables the 64-bit retired-instruction counter.
module wb_commit_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int NREGS = 32,
    localparam int RA_W = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic            in_is_ecall,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_loaded_data,
    output logic            rf_wr_en,
    output logic [RA_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    input  logic            rf_wr_ack,
    output logic            wb_done,
    output logic [63:0]     retire_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, RETIRE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] ent_data_q [DEPTH];
    logic [XLEN-1:0] ent_data_d [DEPTH];
    logic            ent_nw_q   [DEPTH];
    logic            ent_nw_d   [DEPTH];
    logic [RA_W-1:0] ent_rd_q   [DEPTH];
    logic [RA_W-1:0] ent_rd_d   [DEPTH];
    logic            wr_en_q, wr_en_d;
    logic [RA_W-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            done_q, done_d;
    logic            push, pop;
    logic            new_nw;
    logic [XLEN-1:0] new_data;

    assign in_ready   = (count_q < CW'(DEPTH));
    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign wb_done    = done_q;

    // Result is chosen once at push so the head entry is ready to write without re-decoding.
    always_comb begin
        new_nw   = 1'b1;
        new_data = in_alu_result;
        case (in_opcode)
            7'b0110011, 7'b0111011, 7'b0010011,
            7'b0011011, 7'b0010111, 7'b0110111: new_data = in_alu_result;
            7'b0000011:                         new_data = in_loaded_data;
            7'b1101111, 7'b1100111:             new_data = in_pc + XLEN'(4);
            7'b1110011:                         new_nw   = in_is_ecall;
            default:                            new_nw   = 1'b0;
        endcase
        if (in_rd == '0) new_nw = 1'b0;
    end

    always_comb begin
        push       = in_valid && in_ready && !flush;
        pop        = (state_q == RETIRE);
        state_d    = state_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        ent_data_d = ent_data_q;
        ent_nw_d   = ent_nw_q;
        ent_rd_d   = ent_rd_q;
        if (push) begin
            ent_data_d[wr_ptr_q] = new_data;
            ent_nw_d[wr_ptr_q]   = new_nw;
            ent_rd_d[wr_ptr_q]   = in_rd;
        end
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !flush) begin
                    if (ent_nw_q[rd_ptr_q]) begin
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = ent_rd_q[rd_ptr_q];
                        wr_data_d = ent_data_q[rd_ptr_q];
                    end else begin
                        state_d = RETIRE;
                        done_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (rf_wr_ack) begin
                    state_d = RETIRE;
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        // Flush keeps only the head that is already being written or retired.
        if (flush) begin
            wr_ptr_d = rd_ptr_q + PW'(state_q != IDLE);
            count_d  = CW'(state_q == WRITE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_data_q[i] <= '0;
                ent_nw_q[i]   <= 1'b0;
                ent_rd_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            ent_data_q <= ent_data_d;
            ent_nw_q   <= ent_nw_d;
            ent_rd_q   <= ent_rd_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q + 64'(done_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) retire_cnt_q <= '0;
        else       retire_cnt_q <= retire_cnt_d;
    end

    assign retire_count = retire_cnt_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb/tb_wb_commit_queue.sv - randomized and directed bench for wb_commit_queue against an in-order queue model
// Honours WB_RETIRE_CNT_EN when checking retire_count.
module tb_wb_commit_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic        in_is_ecall = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [63:0] in_pc = '0;
    logic [63:0] in_alu_result = '0;
    logic [63:0] in_loaded_data = '0;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
    logic        rf_wr_ack = 1'b0;
    logic        wb_done;
    logic [63:0] retire_count;

    wb_commit_queue #(.XLEN(64), .DEPTH(DEPTH), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_is_ecall(in_is_ecall), .in_rd(in_rd), .in_pc(in_pc),
        .in_alu_result(in_alu_result), .in_loaded_data(in_loaded_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_wr_ack(rf_wr_ack), .wb_done(wb_done), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          nw;
        logic [4:0]  rd;
        logic [63:0] d;
    } ent_t;

    ent_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int en_cycles = 0;
    int wr_cnt = 0;
    int ack_mode = 0;
    bit prev_en = 0;
    bit expect_done = 0;
    bit acked_head = 0;
    int stall = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic ent_t model(input logic [6:0] op, input logic ec, input logic [4:0] rd,
                                   input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] ld);
        ent_t e;
        e.rd = rd;
        e.nw = 1;
        e.d  = alu;
        if (op inside {7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0010111, 7'b0110111})
            e.d = alu;
        else if (op == 7'b0000011)
            e.d = ld;
        else if (op == 7'b1101111 || op == 7'b1100111)
            e.d = pc + 64'd4;
        else if (op == 7'b1110011)
            e.nw = ec;
        else
            e.nw = 0;
        if (rd == 0) e.nw = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ack_mode)
            1:       rf_wr_ack = rf_wr_en && prev_en;
            2:       rf_wr_ack = 1'($urandom % 2);
            default: rf_wr_ack = 1'b0;
        endcase
        prev_en = rf_wr_en;
    end

    // Compare DUT outputs against the queue model, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            expect_done = 0;
            acked_head = 0;
            stall = 0;
        end else begin
            chk("in_ready", in_ready, 64'(q.size() < DEPTH));
            if (expect_done) begin
                chk("done_after_ack", wb_done, 1);
                chk("en_drop_after_ack", rf_wr_en, 0);
            end
            if (rf_wr_en) begin
                en_cycles++;
                if (q.size() == 0 || !q[0].nw) chk("unexpected_write", 1, 0);
                else begin
                    chk("wr_addr", rf_wr_addr, q[0].rd);
                    chk("wr_data", rf_wr_data, q[0].d);
                end
            end
            if (wb_done) begin
                done_cnt++;
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else if (q[0].nw && !acked_head) chk("done_before_ack", 1, 0);
            end
            if (q.size() > 0 && !wb_done) stall++;
            else stall = 0;
            if (stall > 400) begin
                chk("progress_timeout", 0, 1);
                stall = 0;
            end
            expect_done = rf_wr_en && rf_wr_ack;
            if (expect_done) begin
                acked_head = 1;
                wr_cnt++;
            end
            if (wb_done && q.size() > 0) begin
                void'(q.pop_front());
                acked_head = 0;
            end
            if (flush) begin
                if (rf_wr_en) begin
                    while (q.size() > 1) void'(q.pop_back());
                end else begin
                    q.delete();
                end
            end else if (in_valid && in_ready) begin
                q.push_back(model(in_opcode, in_is_ecall, in_rd, in_pc, in_alu_result, in_loaded_data));
            end
        end
    end

    task automatic push(input logic [6:0] op, input logic ec, input logic [4:0] rd,
                        input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] ld);
        int n = 0;
        in_opcode = op; in_is_ecall = ec; in_rd = rd; in_pc = pc;
        in_alu_result = alu; in_loaded_data = ld; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!rf_wr_en && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!rf_wr_en) chk("wait_en_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!wb_done && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!wb_done) chk("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || rf_wr_en || wb_done) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 500) chk("wait_idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    int e, d0, w0, n0;
    logic [6:0] ops [13];

    initial begin
        ops = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0010111, 7'b0110111, 7'b0000011,
                7'b1101111, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011, 7'b0001111};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_wb_done", wb_done, 0);
        chk("rst_retire_count", retire_count, 0);

        ack_mode = 1;
        push(7'b0010011, 0, 5, 64'h100, 64'h2A, 64'h0);
        e = cyc;
        wait_en();
        chk("addi_en_latency", 64'(cyc - e), 1);
        chk("addi_addr", rf_wr_addr, 5);
        chk("addi_data", rf_wr_data, 64'h2A);
        wait_done();
        chk("addi_done_latency", 64'(cyc - e), 3);

        push(7'b1101111, 0, 1, 64'h1000, 64'hDEAD, 64'h0);
        wait_en();
        chk("jal_addr", rf_wr_addr, 1);
        chk("jal_data", rf_wr_data, 64'h1004);
        wait_done();

        @(posedge clk); #1;
        n0 = en_cycles;
        push(7'b1101111, 0, 0, 64'h2000, 64'h0, 64'h0);
        e = cyc;
        wait_done();
        chk("jal_x0_done_latency", 64'(cyc - e), 1);
        chk("jal_x0_no_write", 64'(en_cycles - n0), 0);
        wait_idle();

        ack_mode = 0;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) push(7'b0000011, 0, 5'(i + 1), 64'h0, 64'h0, 64'h100 + 64'(i));
        chk("full_in_ready", in_ready, 0);
        in_opcode = 7'b0010011; in_rd = 10; in_alu_result = 64'h55; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", in_ready, 0);
        end
        ack_mode = 1;
        push(7'b0010011, 0, 10, 64'h0, 64'h55, 64'h0);
        wait_idle();
        chk("fill_writes", 64'(wr_cnt - w0), 5);

        ack_mode = 0;
        push(7'b0010011, 0, 3, 64'h0, 64'h33, 64'h0);
        wait_en();
        #2 reset = 1'b1;
        #1 chk("rst_async_en", rf_wr_en, 0);
        @(posedge clk); #1;
        chk("rst_no_done", wb_done, 0);
        reset = 1'b0;

        ack_mode = 1;
        d0 = done_cnt; n0 = en_cycles;
        push(7'b0100011, 0, 2, 64'h0, 64'h1, 64'h0);
        push(7'b1100011, 0, 3, 64'h0, 64'h2, 64'h0);
        push(7'b0001111, 0, 4, 64'h0, 64'h3, 64'h0);
        push(7'b1110011, 0, 5, 64'h0, 64'h4, 64'h0);
        wait_idle();
        chk("nowrite_done_pulses", 64'(done_cnt - d0), 4);
        chk("nowrite_no_en", 64'(en_cycles - n0), 0);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_count_4", retire_count, 4);
`else
        chk("retire_count_tied", retire_count, 0);
`endif

        ack_mode = 0;
        d0 = done_cnt; w0 = wr_cnt;
        push(7'b0010011, 0, 7, 64'h0, 64'h7, 64'h0);
        push(7'b0010011, 0, 8, 64'h0, 64'h8, 64'h0);
        push(7'b0010011, 0, 9, 64'h0, 64'h9, 64'h0);
        wait_en();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        ack_mode = 1;
        wait_idle();
        chk("flush_done_pulses", 64'(done_cnt - d0), 1);
        chk("flush_writes", 64'(wr_cnt - w0), 1);
        chk("flush_in_ready", in_ready, 1);

        ack_mode = 2;
        d0 = done_cnt;
        for (int i = 0; i < 1500; i++) begin
            in_valid       = 1'($urandom % 3 != 0);
            in_opcode      = ($urandom % 8 == 0) ? 7'($urandom) : ops[$urandom % 13];
            in_is_ecall    = 1'($urandom);
            in_rd          = 5'($urandom);
            in_pc          = {$urandom, $urandom};
            in_alu_result  = {$urandom, $urandom};
            in_loaded_data = {$urandom, $urandom};
            if (i % 100 < 50) in_pc = 64'hFFFF_FFFF_FFFF_FFFC;
            flush          = ($urandom % 40 == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        ack_mode = 1;
        wait_idle();
        chk("random_retired_some", 64'(done_cnt - d0 > 100), 1);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_count_total", retire_count, 64'(done_cnt - d0 + 4 + 1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
